cmd_rx_pkt: RTL and testbench

CMD_RX_PKT -- requirements
Module: cmd_rx_pkt

---
 rtl/cmd_rx_pkt.sv | 232 +++++++++++++++++++++++
 tb/tb_cmd_rx_pkt.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_rx_pkt.sv
// cmd_rx_pkt: byte-stream command frame receiver.
// Frame format: SYNC, OP, COUNT, ADDR_BYTES address bytes (LSB first), CRC-8.
// The CRC covers OP, COUNT and the address bytes. A frame that passes the
// check is presented as a held request on the mreq valid/ready handshake.
// Optional feature: define CMD_RX_PKT_TIMEOUT_EN to enable the inter-byte
// timeout, which abandons a frame that stalls for TIMEOUT_CYCLES cycles.
module cmd_rx_pkt #(
  parameter int         ADDR_BYTES     = 4,
  parameter logic [7:0] SYNC_BYTE      = 8'hA3,
  parameter logic [7:0] CRC_POLY       = 8'h07,
  parameter int         TIMEOUT_CYCLES = 1024,
  parameter int         CNT_W          = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  // byte stream
  input  logic                    i_rx_valid,
  input  logic [7:0]              i_rx_data,
  output logic                    o_rx_ready,
  // request
  output logic                    o_mreq_valid,
  input  logic                    i_mreq_ready,
  output logic                    o_mreq_wr,
  output logic                    o_mreq_aincr,
  output logic [1:0]              o_mreq_wsize,
  output logic [7:0]              o_mreq_wcount,
  output logic [8*ADDR_BYTES-1:0] o_mreq_addr,
  // status
  output logic                    o_err_crc,
  output logic                    o_err_timeout,
  output logic [CNT_W-1:0]        o_crc_err_cnt,
  output logic [CNT_W-1:0]        o_timeout_cnt
);

  typedef enum logic [2:0] {
    S_HUNT,
    S_OP,
    S_CNT,
    S_ADDR,
    S_CRC,
    S_OUT
  } state_t;

  // Index of the final address byte; the index register is 3 bits since
  // ADDR_BYTES never exceeds 4.
  localparam logic [2:0] LAST_IDX = 3'(ADDR_BYTES - 1);

  state_t                  state_q, state_d;
  logic                    rx_fire;
  logic                    crc_match;
  logic                    crc_fail;
  logic                    timeout_hit;

  logic [7:0]              crc_q;
  logic                    op_wr_q;
  logic                    op_aincr_q;
  logic [1:0]              op_wsize_q;
  logic [7:0]              cnt_q;
  logic [8*ADDR_BYTES-1:0] addr_q;
  logic [2:0]              idx_q;

  // One byte of CRC-8, MSB first, no reflection.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

  // Ready everywhere except while a request is pending; a byte moves only
  // when both sides agree.
  assign o_rx_ready   = (state_q != S_OUT);
  assign o_mreq_valid = (state_q == S_OUT);
  assign rx_fire      = i_rx_valid && o_rx_ready;

  // Next-state decode and the CRC verdict for the closing byte.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    crc_match = 1'b0;
    crc_fail  = 1'b0;
    unique case (state_q)
      S_HUNT: if (rx_fire && (i_rx_data == SYNC_BYTE)) state_d = S_OP;
      S_OP:   if (rx_fire) state_d = S_CNT;
      S_CNT:  if (rx_fire) state_d = S_ADDR;
      S_ADDR: if (rx_fire && (idx_q == LAST_IDX)) state_d = S_CRC;
      S_CRC: begin
        if (rx_fire) begin
          if (i_rx_data == crc_q) begin
            crc_match = 1'b1;
            state_d   = S_OUT;
          end else begin
            crc_fail = 1'b1;
            state_d  = S_HUNT;
          end
        end
      end
      S_OUT:  if (i_mreq_ready) state_d = S_HUNT;
      default: state_d = S_HUNT;
    endcase
    // A stalled frame is abandoned; the timer never fires on a cycle that
    // accepts a byte, so this cannot collide with the decisions above.
    if (timeout_hit) state_d = S_HUNT;
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!i_rst_n) state_q <= S_HUNT;
    else          state_q <= state_d;
  end

  // Running CRC: cleared while hunting, folded in over OP, COUNT and address.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      crc_q <= 8'h00;
    end else if (rx_fire) begin
      case (state_q)
        S_HUNT:              crc_q <= 8'h00;
        S_OP, S_CNT, S_ADDR: crc_q <= crc8_byte(crc_q, i_rx_data);
        default:             crc_q <= crc_q;
      endcase
    end
  end

  // Field capture; address bytes land little-endian by index.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_wr_q    <= 1'b0;
      op_aincr_q <= 1'b0;
      op_wsize_q <= 2'b00;
      cnt_q      <= 8'h00;
      addr_q     <= '0;
      idx_q      <= 3'd0;
    end else if (rx_fire) begin
      case (state_q)
        S_OP: begin
          op_wr_q    <= i_rx_data[0];
          op_aincr_q <= i_rx_data[3];
          op_wsize_q <= i_rx_data[5:4];
        end
        S_CNT: begin
          cnt_q <= i_rx_data;
          idx_q <= 3'd0;
        end
        S_ADDR: begin
          for (int k = 0; k < ADDR_BYTES; k++) begin
            if (idx_q == 3'(k)) addr_q[8*k +: 8] <= i_rx_data;
          end
          idx_q <= idx_q + 3'd1;
        end
        default: ;
      endcase
    end
  end

  // Request fields load only on a good CRC and stay put through OUT.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_mreq_wr     <= 1'b0;
      o_mreq_aincr  <= 1'b0;
      o_mreq_wsize  <= 2'b00;
      o_mreq_wcount <= 8'h00;
      o_mreq_addr   <= '0;
    end else if (crc_match) begin
      o_mreq_wr     <= op_wr_q;
      o_mreq_aincr  <= op_aincr_q;
      o_mreq_wsize  <= op_wsize_q;
      o_mreq_wcount <= cnt_q;
      o_mreq_addr   <= addr_q;
    end
  end

  // CRC error pulse and saturating error count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_err_crc     <= 1'b0;
      o_crc_err_cnt <= '0;
    end else begin
      o_err_crc <= crc_fail;
      if (crc_fail && (o_crc_err_cnt != {CNT_W{1'b1}})) begin
        o_crc_err_cnt <= o_crc_err_cnt + CNT_W'(1);
      end
    end
  end

`ifdef CMD_RX_PKT_TIMEOUT_EN
  localparam int               TMR_W     = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES - 1);

  logic             timed_state;
  logic [TMR_W-1:0] timer_q;

  // Only mid-frame states are watched; hunting and a pending request wait forever.
  assign timed_state = (state_q == S_OP) || (state_q == S_CNT) ||
                       (state_q == S_ADDR) || (state_q == S_CRC);
  assign timeout_hit = timed_state && !rx_fire && (timer_q == TMR_LIMIT);

  // Idle-cycle timer, restarted by every accepted byte.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      timer_q <= '0;
    end else if (!timed_state || rx_fire || timeout_hit) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + TMR_W'(1);
    end
  end

  // Timeout pulse and saturating timeout count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_err_timeout <= 1'b0;
      o_timeout_cnt <= '0;
    end else begin
      o_err_timeout <= timeout_hit;
      if (timeout_hit && (o_timeout_cnt != {CNT_W{1'b1}})) begin
        o_timeout_cnt <= o_timeout_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign timeout_hit   = 1'b0;
  assign o_err_timeout = 1'b0;
  assign o_timeout_cnt = '0;
`endif

endmodule

// File: tb/tb_cmd_rx_pkt.sv
// tb_cmd_rx_pkt: directed bench for cmd_rx_pkt.
// u_dut4 uses 4 address bytes and a 16-cycle timeout; u_dut2 uses 2 address
// bytes and 2-bit error counters so saturation is reachable quickly.
module tb_cmd_rx_pkt;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- u_dut4 signals ----------------
  logic        rst4_n = 1'b1;
  logic        rx_valid4 = 1'b0;
  logic [7:0]  rx_data4 = 8'h00;
  logic        rx_ready4;
  logic        mreq_valid4;
  logic        mreq_ready4 = 1'b0;
  logic        wr4, aincr4;
  logic [1:0]  wsize4;
  logic [7:0]  wcount4;
  logic [31:0] addr4;
  logic        err_crc4, err_to4;
  logic [7:0]  crc_cnt4, to_cnt4;

  // ---------------- u_dut2 signals ----------------
  logic        rst2_n = 1'b1;
  logic        rx_valid2 = 1'b0;
  logic [7:0]  rx_data2 = 8'h00;
  logic        rx_ready2;
  logic        mreq_valid2;
  logic        mreq_ready2 = 1'b0;
  logic        wr2, aincr2;
  logic [1:0]  wsize2;
  logic [7:0]  wcount2;
  logic [15:0] addr2;
  logic        err_crc2, err_to2;
  logic [1:0]  crc_cnt2, to_cnt2;

  int n_pass  = 0;
  int n_total = 0;

  // Observed-event tallies, sampled on every negedge a task passes through.
  int cyc4 = 0, n_valid4 = 0, n_crc4 = 0, n_to4 = 0;
  int n_valid2 = 0, n_crc2 = 0;

  cmd_rx_pkt #(
    .ADDR_BYTES(4), .SYNC_BYTE(8'hA3), .CRC_POLY(8'h07),
    .TIMEOUT_CYCLES(16), .CNT_W(8)
  ) u_dut4 (
    .i_clk(clk), .i_rst_n(rst4_n),
    .i_rx_valid(rx_valid4), .i_rx_data(rx_data4), .o_rx_ready(rx_ready4),
    .o_mreq_valid(mreq_valid4), .i_mreq_ready(mreq_ready4),
    .o_mreq_wr(wr4), .o_mreq_aincr(aincr4), .o_mreq_wsize(wsize4),
    .o_mreq_wcount(wcount4), .o_mreq_addr(addr4),
    .o_err_crc(err_crc4), .o_err_timeout(err_to4),
    .o_crc_err_cnt(crc_cnt4), .o_timeout_cnt(to_cnt4)
  );

  cmd_rx_pkt #(
    .ADDR_BYTES(2), .SYNC_BYTE(8'hA3), .CRC_POLY(8'h07),
    .TIMEOUT_CYCLES(16), .CNT_W(2)
  ) u_dut2 (
    .i_clk(clk), .i_rst_n(rst2_n),
    .i_rx_valid(rx_valid2), .i_rx_data(rx_data2), .o_rx_ready(rx_ready2),
    .o_mreq_valid(mreq_valid2), .i_mreq_ready(mreq_ready2),
    .o_mreq_wr(wr2), .o_mreq_aincr(aincr2), .o_mreq_wsize(wsize2),
    .o_mreq_wcount(wcount2), .o_mreq_addr(addr2),
    .o_err_crc(err_crc2), .o_err_timeout(err_to2),
    .o_crc_err_cnt(crc_cnt2), .o_timeout_cnt(to_cnt2)
  );

  // Bit-serial CRC-8/0x07 reference used to build frame trailers.
  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    logic       fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[7] ^ d[i];
      r  = {r[6:0], 1'b0};
      if (fb) r = r ^ 8'h07;
    end
    return r;
  endfunction

  function automatic logic [7:0] frame_crc4(input logic [7:0] op, input logic [7:0] cnt,
                                            input logic [31:0] addr);
    logic [7:0] c;
    c = crc_step(8'h00, op);
    c = crc_step(c, cnt);
    for (int k = 0; k < 4; k++) c = crc_step(c, addr[8*k +: 8]);
    return c;
  endfunction

  function automatic logic [7:0] frame_crc2(input logic [7:0] op, input logic [7:0] cnt,
                                            input logic [15:0] addr);
    logic [7:0] c;
    c = crc_step(8'h00, op);
    c = crc_step(c, cnt);
    for (int k = 0; k < 2; k++) c = crc_step(c, addr[8*k +: 8]);
    return c;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick4();
    @(negedge clk);
    cyc4++;
    if (mreq_valid4) n_valid4++;
    if (err_crc4)    n_crc4++;
    if (err_to4)     n_to4++;
  endtask

  task automatic tick2();
    @(negedge clk);
    if (mreq_valid2) n_valid2++;
    if (err_crc2)    n_crc2++;
  endtask

  task automatic send4(input logic [7:0] b);
    int n;
    n = 0;
    rx_valid4 = 1'b1;
    rx_data4  = b;
    while (!rx_ready4 && n < 200) begin
      tick4();
      n++;
    end
    if (!rx_ready4) begin
      n_total++;
      $display("FAIL send4_ready: rx_ready=%0b after %0d cycles, want 1", rx_ready4, n);
    end
    tick4();
    rx_valid4 = 1'b0;
  endtask

  task automatic send2(input logic [7:0] b);
    int n;
    n = 0;
    rx_valid2 = 1'b1;
    rx_data2  = b;
    while (!rx_ready2 && n < 200) begin
      tick2();
      n++;
    end
    if (!rx_ready2) begin
      n_total++;
      $display("FAIL send2_ready: rx_ready=%0b after %0d cycles, want 1", rx_ready2, n);
    end
    tick2();
    rx_valid2 = 1'b0;
  endtask

  task automatic send_frame4(input logic [7:0] op, input logic [7:0] cnt,
                             input logic [31:0] addr, input logic bad);
    logic [7:0] c;
    c = frame_crc4(op, cnt, addr);
    send4(8'hA3);
    send4(op);
    send4(cnt);
    for (int k = 0; k < 4; k++) send4(addr[8*k +: 8]);
    send4(bad ? ~c : c);
  endtask

  task automatic send_frame2(input logic [7:0] op, input logic [7:0] cnt,
                             input logic [15:0] addr, input logic bad);
    logic [7:0] c;
    c = frame_crc2(op, cnt, addr);
    send2(8'hA3);
    send2(op);
    send2(cnt);
    for (int k = 0; k < 2; k++) send2(addr[8*k +: 8]);
    send2(bad ? ~c : c);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #1;
    rst4_n = 1'b0;
    rst2_n = 1'b0;
    #2;
    n_total++;
    if (rx_ready4 !== 1'b1) $display("FAIL rst_ready: got %0b want 1", rx_ready4); else n_pass++;
    n_total++;
    if (mreq_valid4 !== 1'b0) $display("FAIL rst_valid: got %0b want 0", mreq_valid4); else n_pass++;
    n_total++;
    if ({wr4, aincr4, wsize4, wcount4, addr4} !== 44'h0)
      $display("FAIL rst_fields: got %h want 0", {wr4, aincr4, wsize4, wcount4, addr4});
    else n_pass++;
    n_total++;
    if ({crc_cnt4, to_cnt4, err_crc4, err_to4} !== 18'h0)
      $display("FAIL rst_status: got %h want 0", {crc_cnt4, to_cnt4, err_crc4, err_to4});
    else n_pass++;
    repeat (2) @(negedge clk);
    rst4_n = 1'b1;
    rst2_n = 1'b1;
    #1;
    n_total++;
    if (rx_ready4 !== 1'b1 || rx_ready2 !== 1'b1)
      $display("FAIL rst_release_ready: got %0b%0b want 11", rx_ready4, rx_ready2);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_noise();
    logic [7:0] junk [11];
    junk = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h23, 8'hFE, 8'h01, 8'h00, 8'hFA, 8'h77};
    for (int i = 0; i < 11; i++) send4(junk[i]);
    repeat (3) tick4();
    n_total++;
    if (n_valid4 !== 0) $display("FAIL noise_valid: got %0d valid cycles want 0", n_valid4); else n_pass++;
    n_total++;
    if (n_crc4 + n_to4 !== 0) $display("FAIL noise_pulses: got %0d want 0", n_crc4 + n_to4); else n_pass++;
    n_total++;
    if (crc_cnt4 !== 8'd0 || to_cnt4 !== 8'd0)
      $display("FAIL noise_counters: got %0d/%0d want 0/0", crc_cnt4, to_cnt4);
    else n_pass++;
  endtask

  task automatic test_crc_error();
    send_frame4(8'h00, 8'h00, 32'h0, 1'b1);
    n_total++;
    if (err_crc4 !== 1'b1) $display("FAIL crc_err_pulse: got %0b want 1", err_crc4); else n_pass++;
    n_total++;
    if (crc_cnt4 !== 8'd1) $display("FAIL crc_err_cnt: got %0d want 1", crc_cnt4); else n_pass++;
    tick4();
    n_total++;
    if (err_crc4 !== 1'b0) $display("FAIL crc_err_width: got %0b want 0", err_crc4); else n_pass++;
    repeat (2) tick4();
    n_total++;
    if (n_crc4 !== 1 || n_valid4 !== 0)
      $display("FAIL crc_err_events: got pulses=%0d valid=%0d want 1/0", n_crc4, n_valid4);
    else n_pass++;
  endtask

  task automatic test_good_frame();
    mreq_ready4 = 1'b0;
    send4(8'hA3);
    send4(8'h09);
    send4(8'h05);
    send4(8'h78);
    send4(8'h56);
    send4(8'h34);
    send4(8'h12);
    n_total++;
    if (mreq_valid4 !== 1'b0) $display("FAIL good_early_valid: got %0b want 0", mreq_valid4); else n_pass++;
    send4(frame_crc4(8'h09, 8'h05, 32'h12345678));
    n_total++;
    if (mreq_valid4 !== 1'b1) $display("FAIL good_valid: got %0b want 1", mreq_valid4); else n_pass++;
    n_total++;
    if ({wr4, aincr4, wsize4} !== 4'b1100)
      $display("FAIL good_op: got wr=%0b aincr=%0b wsize=%0d want 1/1/0", wr4, aincr4, wsize4);
    else n_pass++;
    n_total++;
    if (wcount4 !== 8'd5) $display("FAIL good_wcount: got %0d want 5", wcount4); else n_pass++;
    n_total++;
    if (addr4 !== 32'h12345678) $display("FAIL good_addr: got %h want 12345678", addr4); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic ok;
    ok = 1'b1;
    // Next frame's SYNC is offered throughout the stall and must not be taken.
    rx_valid4 = 1'b1;
    rx_data4  = 8'hA3;
    for (int i = 0; i < 30; i++) begin
      tick4();
      if (rx_ready4 !== 1'b0 || mreq_valid4 !== 1'b1 || wr4 !== 1'b1 || aincr4 !== 1'b1 ||
          wsize4 !== 2'd0 || wcount4 !== 8'd5 || addr4 !== 32'h12345678) ok = 1'b0;
    end
    n_total++;
    if (ok !== 1'b1) $display("FAIL bp_hold: stable=%0b want 1", ok); else n_pass++;
    mreq_ready4 = 1'b1;
    tick4();
    mreq_ready4 = 1'b0;
    n_total++;
    if (mreq_valid4 !== 1'b0) $display("FAIL bp_release_valid: got %0b want 0", mreq_valid4); else n_pass++;
    n_total++;
    if (rx_ready4 !== 1'b1) $display("FAIL bp_release_ready: got %0b want 1", rx_ready4); else n_pass++;
    send_frame4(8'h18, 8'h05, 32'h87654321, 1'b0);
    n_total++;
    if (mreq_valid4 !== 1'b1) $display("FAIL bp_next_valid: got %0b want 1", mreq_valid4); else n_pass++;
    n_total++;
    if ({wr4, aincr4, wsize4} !== 4'b0101)
      $display("FAIL bp_next_op: got wr=%0b aincr=%0b wsize=%0d want 0/1/1", wr4, aincr4, wsize4);
    else n_pass++;
    n_total++;
    if (addr4 !== 32'h87654321 || wcount4 !== 8'd5)
      $display("FAIL bp_next_addr: got %h/%0d want 87654321/5", addr4, wcount4);
    else n_pass++;
    mreq_ready4 = 1'b1;
    tick4();
    mreq_ready4 = 1'b0;
  endtask

  task automatic test_timeout();
    int to_before;
    to_before = n_to4;
    send4(8'hA3);
    send4(8'h09);
    repeat (20) tick4();
`ifdef CMD_RX_PKT_TIMEOUT_EN
    n_total++;
    if (n_to4 - to_before !== 1) $display("FAIL to_pulse: got %0d pulses want 1", n_to4 - to_before); else n_pass++;
    n_total++;
    if (to_cnt4 !== 8'd1) $display("FAIL to_cnt: got %0d want 1", to_cnt4); else n_pass++;
    send_frame4(8'h09, 8'h05, 32'h12345678, 1'b0);
`else
    n_total++;
    if (n_to4 - to_before !== 0) $display("FAIL to_pulse: got %0d pulses want 0", n_to4 - to_before); else n_pass++;
    n_total++;
    if (to_cnt4 !== 8'd0) $display("FAIL to_cnt: got %0d want 0", to_cnt4); else n_pass++;
    // Without the timer the stalled frame is still open; finish it.
    send4(8'h05);
    send4(8'h78);
    send4(8'h56);
    send4(8'h34);
    send4(8'h12);
    send4(frame_crc4(8'h09, 8'h05, 32'h12345678));
`endif
    n_total++;
    if (mreq_valid4 !== 1'b1 || addr4 !== 32'h12345678 || wr4 !== 1'b1 || wcount4 !== 8'd5)
      $display("FAIL to_next_frame: got valid=%0b addr=%h wr=%0b cnt=%0d want 1/12345678/1/5",
               mreq_valid4, addr4, wr4, wcount4);
    else n_pass++;
    mreq_ready4 = 1'b1;
    tick4();
    mreq_ready4 = 1'b0;
  endtask

  task automatic test_back_to_back();
    int start;
    mreq_ready4 = 1'b1;
    start = cyc4;
    send_frame4(8'h01, 8'h02, 32'hA300A311, 1'b0);
    n_total++;
    if (mreq_valid4 !== 1'b1 || addr4 !== 32'hA300A311 || wcount4 !== 8'd2)
      $display("FAIL b2b_first: got valid=%0b addr=%h cnt=%0d want 1/a300a311/2",
               mreq_valid4, addr4, wcount4);
    else n_pass++;
    send_frame4(8'h30, 8'hFF, 32'hDEADBEEF, 1'b0);
    n_total++;
    if (mreq_valid4 !== 1'b1 || addr4 !== 32'hDEADBEEF || wsize4 !== 2'd3 || wr4 !== 1'b0)
      $display("FAIL b2b_second: got valid=%0b addr=%h wsize=%0d wr=%0b want 1/deadbeef/3/0",
               mreq_valid4, addr4, wsize4, wr4);
    else n_pass++;
    n_total++;
    if (cyc4 - start !== 17) $display("FAIL b2b_cycles: got %0d want 17", cyc4 - start); else n_pass++;
    tick4();
    n_total++;
    if (mreq_valid4 !== 1'b0) $display("FAIL b2b_drain: got %0b want 0", mreq_valid4); else n_pass++;
    mreq_ready4 = 1'b0;
  endtask

  task automatic test_addr2_reset();
    int crc_before;
    crc_before = n_crc2;
    send2(8'hA3);
    send2(8'h09);
    send2(8'h05);
    send2(8'h78);
    rst2_n = 1'b0;
    #1;
    n_total++;
    if (rx_ready2 !== 1'b1 || mreq_valid2 !== 1'b0)
      $display("FAIL a2_rst_mid: got ready=%0b valid=%0b want 1/0", rx_ready2, mreq_valid2);
    else n_pass++;
    repeat (2) tick2();
    rst2_n = 1'b1;
    tick2();
    n_total++;
    if (n_valid2 !== 0 || n_crc2 - crc_before !== 0)
      $display("FAIL a2_no_stale: got valid=%0d crc_pulses=%0d want 0/0", n_valid2, n_crc2 - crc_before);
    else n_pass++;
    mreq_ready2 = 1'b0;
    send_frame2(8'h01, 8'h03, 16'hABCD, 1'b0);
    n_total++;
    if (mreq_valid2 !== 1'b1 || addr2 !== 16'hABCD || wr2 !== 1'b1 || wcount2 !== 8'd3)
      $display("FAIL a2_frame: got valid=%0b addr=%h wr=%0b cnt=%0d want 1/abcd/1/3",
               mreq_valid2, addr2, wr2, wcount2);
    else n_pass++;
    // Reset while a request is pending drops it.
    rst2_n = 1'b0;
    #1;
    n_total++;
    if (mreq_valid2 !== 1'b0 || addr2 !== 16'h0)
      $display("FAIL a2_rst_out: got valid=%0b addr=%h want 0/0000", mreq_valid2, addr2);
    else n_pass++;
    tick2();
    rst2_n = 1'b1;
    tick2();
    n_total++;
    if (mreq_valid2 !== 1'b0 || err_crc2 !== 1'b0)
      $display("FAIL a2_rst_out_after: got valid=%0b err=%0b want 0/0", mreq_valid2, err_crc2);
    else n_pass++;
  endtask

  task automatic test_sync_in_frame();
    send_frame2(8'hA3, 8'hA3, 16'hA3A3, 1'b0);
    n_total++;
    if ({wr2, aincr2, wsize2} !== 4'b1010)
      $display("FAIL sif_op: got wr=%0b aincr=%0b wsize=%0d want 1/0/2", wr2, aincr2, wsize2);
    else n_pass++;
    n_total++;
    if (mreq_valid2 !== 1'b1 || addr2 !== 16'hA3A3 || wcount2 !== 8'hA3)
      $display("FAIL sif_data: got valid=%0b addr=%h cnt=%h want 1/a3a3/a3", mreq_valid2, addr2, wcount2);
    else n_pass++;
    mreq_ready2 = 1'b1;
    tick2();
    mreq_ready2 = 1'b0;
  endtask

  task automatic test_saturation();
    int crc_before;
    crc_before = n_crc2;
    for (int i = 0; i < 4; i++) send_frame2(8'h11, 8'h22, 16'h3344, 1'b1);
    repeat (2) tick2();
    n_total++;
    if (n_crc2 - crc_before !== 4) $display("FAIL sat_pulses: got %0d want 4", n_crc2 - crc_before); else n_pass++;
    n_total++;
    if (crc_cnt2 !== 2'b11) $display("FAIL sat_cnt: got %0d want 3", crc_cnt2); else n_pass++;
    n_total++;
    if (to_cnt2 !== 2'b00) $display("FAIL sat_to_cnt: got %0d want 0", to_cnt2); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_noise();
    test_crc_error();
    test_good_frame();
    test_backpressure();
    test_timeout();
    test_back_to_back();
    test_addr2_reset();
    test_sync_in_frame();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

endmodule
